// File: rtl/img_conv_host_if.sv
// img_conv_host_if
// Host-side front end for img_conv_top. Turns a byte-serial valid/ready
// command stream into single-cycle op/en/din requests for the convolution
// core, and returns response bytes (GET results, TX image bytes, acks and
// error codes) through an internal output FIFO on a valid/ready stream.
// Shadow copies of nrows/ncols are kept so RX/TX bursts can be sized.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_data_i/s_valid_i/s_ready_o  host command/payload byte stream
//   m_data_o/m_valid_o/m_ready_i  response byte stream (FIFO head)
//   conv_op_o/conv_en_o/conv_din_o  request towards img_conv_top
//   conv_dout_i/conv_busy_i       data and busy back from img_conv_top
//   err_underrun_o                sticky: host starved an RX burst
//   err_overflow_o                sticky: response byte dropped on full FIFO
//   idle_o                        FSM idle and FIFO empty

package img_conv_pkg;
    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_GET_NROWS = 4'h1,
        OP_GET_NCOLS = 4'h2,
        OP_GET_SIGMA = 4'h3,
        OP_SET_NROWS = 4'h4,
        OP_SET_NCOLS = 4'h5,
        OP_SET_SIGMA = 4'h6,
        OP_IMG_RX    = 4'h7,
        OP_IMG_TX    = 4'h8,
        OP_CONV      = 4'h9
    } opcode_t;
endpackage

module img_conv_host_if
    import img_conv_pkg::*;
#(
    parameter int OFIFO_DEPTH = 16,
    parameter int GET_LAT     = 2,
    parameter int TX_LAT      = 2,
    parameter int CONV_WAIT   = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic [7:0] m_data_o,
    output logic       m_valid_o,
    input  logic       m_ready_i,
    output opcode_t    conv_op_o,
    output logic       conv_en_o,
    output logic [7:0] conv_din_o,
    input  logic [7:0] conv_dout_i,
    input  logic       conv_busy_i,
    output logic       err_underrun_o,
    output logic       err_overflow_o,
    output logic       idle_o
);

    localparam int AW = $clog2(OFIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_ISSUE, S_GET_WAIT,
        S_RX_BURST, S_TX_WAIT, S_TX_BURST, S_CONV_WAIT
    } state_t;

    state_t      state_q, state_d;
    opcode_t     cmd_q, cmd_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  din_q, din_d;
    logic [7:0]  nrows_q, nrows_d, ncols_q, ncols_d;
    logic        under_q, under_d;
    logic        over_q;
    logic        s_ready_c;
    logic        push;
    logic [7:0]  push_data;

    logic [7:0]  mem_q [OFIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] count_q;
    logic        fifo_empty, fifo_full, pop, push_ok;

    logic [7:0]  eff_r, eff_c;
    logic [15:0] n_w;
    logic        last_w;

    // Burst length: a zero dimension is treated as one so a burst is never empty.
    assign eff_r  = (nrows_q == 8'd0) ? 8'd1 : nrows_q;
    assign eff_c  = (ncols_q == 8'd0) ? 8'd1 : ncols_q;
    assign n_w    = 16'(eff_r) * 16'(eff_c);
    assign last_w = (cnt_q == n_w - 16'd1);

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(OFIFO_DEPTH));
    assign pop        = m_ready_i && !fifo_empty;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign push_ok    = push && (!fifo_full || pop);

    // Next-state and command-side outputs. conv_din follows the host byte
    // combinationally during RX so pixel k lands in burst cycle k.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        nrows_d    = nrows_q;
        ncols_d    = ncols_q;
        under_d    = under_q;
        push       = 1'b0;
        push_data  = 8'h00;
        s_ready_c  = 1'b0;
        conv_en_o  = 1'b0;
        conv_op_o  = OP_NOP;
        conv_din_o = din_q;
        case (state_q)
            S_IDLE: begin
                s_ready_c = !fifo_full;
                if (s_valid_i && !fifo_full) begin
                    cnt_d   = 16'd0;
                    state_d = S_ISSUE;
                    case (s_data_i)
                        8'h01: cmd_d = OP_GET_NROWS;
                        8'h02: cmd_d = OP_GET_NCOLS;
                        8'h03: cmd_d = OP_GET_SIGMA;
                        8'h11: begin cmd_d = OP_SET_NROWS; state_d = S_ARG; end
                        8'h12: begin cmd_d = OP_SET_NCOLS; state_d = S_ARG; end
                        8'h13: begin cmd_d = OP_SET_SIGMA; state_d = S_ARG; end
                        8'h20: cmd_d = OP_IMG_RX;
                        8'h21: cmd_d = OP_IMG_TX;
                        8'h30: cmd_d = OP_CONV;
                        default: begin
                            push      = 1'b1;
                            push_data = 8'hEE;
                            state_d   = S_IDLE;
                        end
                    endcase
                end
            end
            S_ARG: begin
                s_ready_c = 1'b1;
                if (s_valid_i) begin
                    din_d = s_data_i;
                    if (cmd_q == OP_SET_NROWS) nrows_d = s_data_i;
                    if (cmd_q == OP_SET_NCOLS) ncols_d = s_data_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                conv_en_o = 1'b1;
                conv_op_o = cmd_q;
                cnt_d     = 16'd0;
                case (cmd_q)
                    OP_SET_NROWS, OP_SET_NCOLS, OP_SET_SIGMA: begin
                        push      = 1'b1;
                        push_data = 8'hA5;
                        state_d   = S_IDLE;
                    end
                    OP_GET_NROWS, OP_GET_NCOLS, OP_GET_SIGMA: state_d = S_GET_WAIT;
                    OP_IMG_RX: state_d = S_RX_BURST;
                    OP_IMG_TX: state_d = (TX_LAT <= 1) ? S_TX_BURST : S_TX_WAIT;
                    OP_CONV:   state_d = S_CONV_WAIT;
                    default:   state_d = S_IDLE;
                endcase
            end
            S_GET_WAIT: begin
                if (cnt_q >= 16'(GET_LAT - 1)) begin
                    push      = 1'b1;
                    push_data = conv_dout_i;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_RX_BURST: begin
                // The core is never stalled: a missing byte becomes 0x00 and is flagged.
                s_ready_c  = 1'b1;
                conv_din_o = s_valid_i ? s_data_i : 8'h00;
                if (!s_valid_i) under_d = 1'b1;
                if (last_w) begin
                    push      = 1'b1;
                    push_data = 8'hA5;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TX_WAIT: begin
                if (cnt_q >= 16'(TX_LAT - 2)) begin
                    cnt_d   = 16'd0;
                    state_d = S_TX_BURST;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TX_BURST: begin
                push      = 1'b1;
                push_data = conv_dout_i;
                if (last_w) state_d = S_IDLE;
                else        cnt_d   = cnt_q + 16'd1;
            end
            S_CONV_WAIT: begin
                // Minimum wait elapsed; keep holding until the core reports not busy.
                if (cnt_q >= 16'(CONV_WAIT - 1)) begin
                    if (!conv_busy_i) begin
                        push      = 1'b1;
                        push_data = 8'hA5;
                        state_d   = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state registers; shadow dimensions reset to the core's 8x8 default.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cmd_q   <= OP_NOP;
            cnt_q   <= 16'd0;
            din_q   <= 8'h00;
            nrows_q <= 8'd8;
            ncols_q <= 8'd8;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            nrows_q <= nrows_d;
            ncols_q <= ncols_d;
            under_q <= under_d;
        end
    end

    // Output FIFO pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            over_q  <= 1'b0;
        end else begin
            if (push_ok) wr_q <= wr_q + AW'(1);
            if (pop)     rd_q <= rd_q + AW'(1);
            count_q <= count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
            if (push && !push_ok) over_q <= 1'b1;
        end
    end

    // Storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= push_data;
    end

    assign s_ready_o      = s_ready_c && !rst;
    assign m_valid_o      = !fifo_empty;
    assign m_data_o       = fifo_empty ? 8'h00 : mem_q[rd_q];
    assign err_underrun_o = under_q;
    assign err_overflow_o = over_q;
    assign idle_o         = (state_q == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_img_conv_host_if.sv
// tb_img_conv_host_if
// Directed bench for img_conv_host_if. Response bytes are predicted into a
// scoreboard queue as commands are issued and compared as the host pops them.

module tb_img_conv_host_if;
    import img_conv_pkg::*;

    localparam int DEPTH     = 16;
    localparam int GET_LAT   = 2;
    localparam int TX_LAT    = 2;
    localparam int CONV_WAIT = 1024;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sData = 8'h00;
    logic       sValid = 1'b0;
    logic       sReady;
    logic [7:0] mData;
    logic       mValid;
    logic       mReady = 1'b1;
    opcode_t    convOp;
    logic       convEn;
    logic [7:0] convDin;
    logic [7:0] convDout = 8'h00;
    logic       convBusy = 1'b0;
    logic       errUnderrun, errOverflow, idle;

    int checks = 0;
    int failures = 0;
    int enCount = 0;
    logic [7:0] expQ[$];

    img_conv_host_if #(
        .OFIFO_DEPTH(DEPTH), .GET_LAT(GET_LAT), .TX_LAT(TX_LAT), .CONV_WAIT(CONV_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data_i(sData), .s_valid_i(sValid), .s_ready_o(sReady),
        .m_data_o(mData), .m_valid_o(mValid), .m_ready_i(mReady),
        .conv_op_o(convOp), .conv_en_o(convEn), .conv_din_o(convDin),
        .conv_dout_i(convDout), .conv_busy_i(convBusy),
        .err_underrun_o(errUnderrun), .err_overflow_o(errOverflow), .idle_o(idle)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Response monitor: every byte the host pops is compared with the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (convEn === 1'b1) enCount++;
        if (mValid === 1'b1 && mReady === 1'b1) begin
            if (expQ.size() == 0) checkOutput("sb_unexpected", 16'(mData), 16'h01FF);
            else                  checkOutput("sb_data", 16'(mData), 16'(expQ.pop_front()));
        end
    end

    // Offers one host byte at a negedge and returns at the negedge after it is taken.
    task automatic applyStimulus(input logic [7:0] b);
        int waitCycles = 0;
        sData  = b;
        sValid = 1'b1;
        while (sReady !== 1'b1 && waitCycles < 200) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 200) checkOutput("accept_timeout", 16'(sReady), 16'd1);
        @(negedge clk);
        sValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (idle !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", 16'(idle), 16'd1);
        checkOutput("sb_drained", 16'(expQ.size()), 16'd0);
    endtask

    task automatic runRx(input int dropIdx);
        expQ.push_back(8'hA5);
        applyStimulus(8'h20);
        checkOutput("rx_en", 16'(convEn), 16'd1);
        checkOutput("rx_op", 16'(convOp), 16'(OP_IMG_RX));
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            sValid = (k != dropIdx);
            sData  = 8'h10 + 8'(k);
            #1;
            checkOutput("rx_ready", 16'(sReady), 16'd1);
            checkOutput("rx_din", 16'(convDin), (k == dropIdx) ? 16'h0000 : 16'(8'h10 + 8'(k)));
            @(negedge clk);
        end
        sValid = 1'b0;
        checkOutput("rx_ack_timing", 16'(mValid), 16'd1);
        waitIdle();
    endtask

    initial begin
        int lat;
        int e0;
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        int e0;
        // Reset values while rst is held.
        repeat (3) @(negedge clk);
        checkOutput("rst_s_ready", 16'(sReady), 16'd0);
        checkOutput("rst_m_valid", 16'(mValid), 16'd0);
        checkOutput("rst_m_data", 16'(mData), 16'd0);
        checkOutput("rst_idle", 16'(idle), 16'd1);
        checkOutput("rst_en", 16'(convEn), 16'd0);
        checkOutput("rst_op", 16'(convOp), 16'(OP_NOP));
        checkOutput("rst_din", 16'(convDin), 16'd0);
        checkOutput("rst_errs", 16'({errUnderrun, errOverflow}), 16'd0);
        rst = 1'b0;
        @(negedge clk);

        // GET_NROWS returns conv_dout GET_LAT+1 cycles after the enable pulse.
        convDout = 8'h08;
        expQ.push_back(8'h08);
        applyStimulus(8'h01);
        checkOutput("get_en", 16'(convEn), 16'd1);
        checkOutput("get_op", 16'(convOp), 16'(OP_GET_NROWS));
        lat = 0;
        while (mValid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("get_latency", 16'(lat), 16'(GET_LAT + 1));
        waitIdle();

        // SET nrows=2, ncols=3.
        expQ.push_back(8'hA5);
        applyStimulus(8'h11);
        applyStimulus(8'h02);
        checkOutput("setr_en", 16'(convEn), 16'd1);
        checkOutput("setr_op", 16'(convOp), 16'(OP_SET_NROWS));
        checkOutput("setr_din", 16'(convDin), 16'h02);
        waitIdle();
        expQ.push_back(8'hA5);
        applyStimulus(8'h12);
        applyStimulus(8'h03);
        checkOutput("setc_en", 16'(convEn), 16'd1);
        checkOutput("setc_op", 16'(convOp), 16'(OP_SET_NCOLS));
        checkOutput("setc_din", 16'(convDin), 16'h03);
        waitIdle();
        checkOutput("op_back_nop", 16'(convOp), 16'(OP_NOP));

        // RX burst of N=6, clean then with a gap on the third burst cycle.
        runRx(-1);
        checkOutput("rx_no_underrun", 16'(errUnderrun), 16'd0);
        runRx(2);
        checkOutput("rx_underrun", 16'(errUnderrun), 16'd1);

        // Reset in the middle of a CONV wait: no ack, flags cleared, dims back to 8x8.
        convBusy = 1'b1;
        applyStimulus(8'h30);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_idle", 16'(idle), 16'd1);
        checkOutput("abort_m_valid", 16'(mValid), 16'd0);
        checkOutput("abort_underrun", 16'(errUnderrun), 16'd0);
        rst = 1'b0;
        convBusy = 1'b0;
        @(negedge clk);

        // TX of 64 bytes into a 16-deep FIFO with the host stalled.
        mReady = 1'b0;
        for (int k = 0; k < DEPTH; k++) expQ.push_back(8'(k));
        applyStimulus(8'h21);
        checkOutput("tx_en", 16'(convEn), 16'd1);
        checkOutput("tx_op", 16'(convOp), 16'(OP_IMG_TX));
        repeat (TX_LAT) @(negedge clk);
        for (int k = 0; k < 64; k++) begin
            convDout = 8'(k);
            @(negedge clk);
        end
        checkOutput("tx_overflow", 16'(errOverflow), 16'd1);
        checkOutput("tx_full_m_valid", 16'(mValid), 16'd1);
        checkOutput("tx_full_s_ready", 16'(sReady), 16'd0);
        checkOutput("tx_full_idle", 16'(idle), 16'd0);
        mReady = 1'b1;
        waitIdle();

        // CONV held off by busy beyond the minimum wait.
        convBusy = 1'b1;
        applyStimulus(8'h30);
        checkOutput("conv_en", 16'(convEn), 16'd1);
        checkOutput("conv_op", 16'(convOp), 16'(OP_CONV));
        repeat (CONV_WAIT + 16) @(negedge clk);
        checkOutput("conv_hold", 16'(mValid), 16'd0);
        expQ.push_back(8'hA5);
        convBusy = 1'b0;
        lat = 0;
        while (mValid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("conv_release_lat", 16'(lat), 16'd1);
        waitIdle();

        // Unknown command byte.
        e0 = enCount;
        expQ.push_back(8'hEE);
        applyStimulus(8'h7F);
        checkOutput("bad_no_en", 16'(convEn), 16'd0);
        waitIdle();
        checkOutput("bad_en_count", 16'(enCount), 16'(e0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
